// File: rtl/nibble_packer.sv
// Pairs incoming 4-bit nibbles into bytes behind one registered output slot.
// A lone in_last nibble is zero-padded; byte_cnt counts delivered bytes.
module nibble_packer #(
  parameter bit HI_FIRST = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_nib,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_last,
  output logic             out_pad,
  output logic [CNT_W-1:0] byte_cnt
);

  // Handshake: a transfer happens on a side in any cycle where valid && ready
  // are both high; valid/data never depend on ready, and in_ready depends
  // only on the output slot (out_valid, out_ready).
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HALF  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         hold_nib_q, hold_nib_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_byte_q, out_byte_d;
  logic               out_last_q, out_last_d;
  logic               out_pad_q, out_pad_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic               accept;
  logic               deliver;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    hold_nib_d  = hold_nib_q;
    out_valid_d = out_valid_q;
    out_byte_d  = out_byte_q;
    out_last_d  = out_last_q;
    out_pad_d   = out_pad_q;
    byte_cnt_d  = byte_cnt_q;

    if (deliver) begin
      out_valid_d = 1'b0;
      byte_cnt_d  = byte_cnt_q + 1'b1;
    end

    // A load in the same cycle as a delivery overrides the clear above.
    if (accept) begin
      unique case (state_q)
        S_EMPTY: begin
          if (in_last) begin
            out_byte_d  = HI_FIRST ? {in_nib, 4'b0000} : {4'b0000, in_nib};
            out_pad_d   = 1'b1;
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            hold_nib_d = in_nib;
            state_d    = S_HALF;
          end
        end
        S_HALF: begin
          out_byte_d  = HI_FIRST ? {hold_nib_q, in_nib} : {in_nib, hold_nib_q};
          out_pad_d   = 1'b0;
          out_last_d  = in_last;
          out_valid_d = 1'b1;
          state_d     = S_EMPTY;
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      hold_nib_q  <= 4'h0;
      out_valid_q <= 1'b0;
      out_byte_q  <= 8'h00;
      out_last_q  <= 1'b0;
      out_pad_q   <= 1'b0;
      byte_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_nib_q  <= hold_nib_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      out_last_q  <= out_last_d;
      out_pad_q   <= out_pad_d;
      byte_cnt_q  <= byte_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign out_last  = out_last_q;
  assign out_pad   = out_pad_q;
  assign byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_nibble_packer.sv
// Directed bench: two packers (high-first/16-bit count, low-first/4-bit count)
// share one input stream; expected bytes and counts are hand-computed.
module tb_nibble_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_nib;
  logic        in_last;
  logic        out_ready;

  logic        rdy_a, rdy_b;
  logic        val_a, val_b;
  logic [7:0]  byte_a, byte_b;
  logic        last_a, last_b;
  logic        pad_a, pad_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nibble_packer #(.HI_FIRST(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy_a), .in_nib(in_nib), .in_last(in_last),
    .out_valid(val_a), .out_ready(out_ready), .out_byte(byte_a),
    .out_last(last_a), .out_pad(pad_a), .byte_cnt(cnt_a)
  );

  nibble_packer #(.HI_FIRST(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy_b), .in_nib(in_nib), .in_last(in_last),
    .out_valid(val_b), .out_ready(out_ready), .out_byte(byte_b),
    .out_last(last_b), .out_pad(pad_b), .byte_cnt(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] n, input logic l);
    in_valid = v;
    in_nib   = n;
    in_last  = l;
  endtask

  // Checks the output slot of both instances plus both byte counters.
  task automatic check_slot(input string tag, input logic v, input logic [7:0] ba,
                            input logic [7:0] bb, input logic l, input logic p,
                            input int cnt);
    check({tag, ".valid_a"}, 32'(val_a), 32'(v));
    check({tag, ".valid_b"}, 32'(val_b), 32'(v));
    if (v) begin
      check({tag, ".byte_a"}, 32'(byte_a), 32'(ba));
      check({tag, ".byte_b"}, 32'(byte_b), 32'(bb));
      check({tag, ".last_a"}, 32'(last_a), 32'(l));
      check({tag, ".last_b"}, 32'(last_b), 32'(l));
      check({tag, ".pad_a"},  32'(pad_a),  32'(p));
      check({tag, ".pad_b"},  32'(pad_b),  32'(p));
    end
    check({tag, ".cnt_a"}, 32'(cnt_a), 32'(cnt & 32'hFFFF));
    check({tag, ".cnt_b"}, 32'(cnt_b), 32'(cnt & 32'hF));
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'h0, 1'b0);
    out_ready = 1'b0;
    cyc();
    cyc();
    // Reset values, all fields including the data registers.
    check("rst.valid", 32'(val_a), 32'd0);
    check("rst.byte",  32'(byte_a), 32'h00);
    check("rst.last",  32'(last_a), 32'd0);
    check("rst.pad",   32'(pad_a),  32'd0);
    check("rst.cnt",   32'(cnt_a),  32'd0);
    rst = 1'b0;
    check("rst.ready", 32'(rdy_a), 32'd1);

    // Pair order.
    out_ready = 1'b1;
    drive(1'b1, 4'hF, 1'b0); cyc();
    check_slot("pair.half", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 0);
    drive(1'b1, 4'h5, 1'b0); cyc();
    check_slot("pair", 1'b1, 8'hF5, 8'h5F, 1'b0, 1'b0, 0);
    drive(1'b0, 4'h0, 1'b0); cyc();
    check_slot("pair.done", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1);

    // Even frame end: no pad byte.
    drive(1'b1, 4'h0, 1'b0); cyc();
    drive(1'b1, 4'hE, 1'b1); cyc();
    check_slot("even", 1'b1, 8'h0E, 8'hE0, 1'b1, 1'b0, 1);
    drive(1'b0, 4'h0, 1'b0); cyc();
    check_slot("even.done", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2);

    // Odd frame end: padded byte, proves the even frame left state EMPTY.
    drive(1'b1, 4'hA, 1'b1); cyc();
    check_slot("odd", 1'b1, 8'hA0, 8'h0A, 1'b1, 1'b1, 2);
    drive(1'b0, 4'h0, 1'b0); cyc();
    check_slot("odd.done", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3);

    // Backpressure with 8'h12 pending.
    out_ready = 1'b0;
    drive(1'b1, 4'h1, 1'b0); cyc();
    drive(1'b1, 4'h2, 1'b0); cyc();
    drive(1'b1, 4'h3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp.ready", 32'(rdy_a), 32'd0);
      check_slot("bp.hold", 1'b1, 8'h12, 8'h21, 1'b0, 1'b0, 3);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(rdy_a), 32'd1);
    cyc();
    check_slot("bp.deliver", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 4);
    drive(1'b1, 4'h4, 1'b0); cyc();
    check_slot("bp.next", 1'b1, 8'h34, 8'h43, 1'b0, 1'b0, 4);

    // Load and delivery in the same cycle: consecutive pad bytes.
    drive(1'b1, 4'hA, 1'b1); cyc();
    check_slot("b2b.first", 1'b1, 8'hA0, 8'h0A, 1'b1, 1'b1, 5);
    drive(1'b1, 4'hB, 1'b1); cyc();
    check_slot("b2b.second", 1'b1, 8'hB0, 8'h0B, 1'b1, 1'b1, 6);
    drive(1'b0, 4'h0, 1'b0); cyc();
    check_slot("b2b.done", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 7);

    // Reset while HALF discards the held nibble.
    drive(1'b1, 4'h7, 1'b0); cyc();
    drive(1'b0, 4'h0, 1'b0);
    rst = 1'b1; cyc(); rst = 1'b0;
    check_slot("mid.rst", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 0);
    drive(1'b1, 4'h3, 1'b0); cyc();
    check_slot("mid.half", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 0);
    drive(1'b1, 4'h4, 1'b0); cyc();
    check_slot("mid.byte", 1'b1, 8'h34, 8'h43, 1'b0, 1'b0, 0);
    drive(1'b0, 4'h0, 1'b0); cyc();
    check_slot("mid.done", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1);
    cyc();
    check_slot("mid.quiet", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1);

    // Reset with a pending byte, and reset beating a simultaneous accept.
    out_ready = 1'b0;
    drive(1'b1, 4'h9, 1'b1); cyc();
    check_slot("pend", 1'b1, 8'h90, 8'h09, 1'b1, 1'b1, 1);
    out_ready = 1'b1;
    drive(1'b1, 4'h6, 1'b1);
    rst = 1'b1; cyc(); rst = 1'b0;
    drive(1'b0, 4'h0, 1'b0);
    check_slot("pend.rst", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 0);

    // Counter wrap: 17 pad bytes back to back; dut_b's 4-bit counter wraps.
    for (int k = 1; k <= 17; k++) begin
      drive(1'b1, 4'(k), 1'b1); cyc();
      check_slot("wrap", 1'b1, {4'(k), 4'h0}, {4'h0, 4'(k)}, 1'b1, 1'b1, k - 1);
    end
    drive(1'b0, 4'h0, 1'b0); cyc();
    check_slot("wrap.done", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 17);
    check("wrap.cnt_b_17", 32'(cnt_b), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
